// File: rtl/jk_mod_counter_if.sv
// Bus bundle for jk_mod_counter: control inputs, count and status outputs.
// The master side drives controls; the counter is the slave.
interface jk_mod_counter_if #(
  parameter int W = 4
);
  logic         EN;
  logic         UP;
  logic         LOAD;
  logic [W-1:0] D;
  logic         OVF_CLR;
  logic [W-1:0] Q;
  logic [W-1:0] J_VEC;
  logic [W-1:0] K_VEC;
  logic         TC;
  logic         LOAD_ERR;
  logic         OVF;

  modport master (
    output EN,
    output UP,
    output LOAD,
    output D,
    output OVF_CLR,
    input  Q,
    input  J_VEC,
    input  K_VEC,
    input  TC,
    input  LOAD_ERR,
    input  OVF
  );

  modport slave (
    input  EN,
    input  UP,
    input  LOAD,
    input  D,
    input  OVF_CLR,
    output Q,
    output J_VEC,
    output K_VEC,
    output TC,
    output LOAD_ERR,
    output OVF
  );
endinterface

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from per-bit JK cells.
// Optional sticky wrap flag OVF enabled by JK_MOD_COUNTER_OVF_EN.
module jk_mod_counter #(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input logic CLK,
  input logic RST_N,
  jk_mod_counter_if.slave bus
);

  generate
    if (MOD < 2 || MOD > (1 << W)) begin : g_bad_mod
      $error("jk_mod_counter: MOD outside 2..2**W");
    end
  endgenerate

  localparam logic [W-1:0] MAX   = W'(MOD - 1);
  localparam logic [W:0]   MOD_X = (W+1)'(MOD);

  logic [W-1:0] q;
  logic [W-1:0] nxt;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] up_nxt;
  logic [W-1:0] dn_nxt;
  logic         d_ok;
  logic         q_ok;
  logic         at_max;
  logic         at_zero;
  logic         m_ld;
  logic         m_err;
  logic         m_up;
  logic         m_dn;
  logic         tc;
  logic         ld_bad;
  logic         load_err;
  logic         ovf;

  assign d_ok    = ({1'b0, bus.D} < MOD_X);
  assign q_ok    = ({1'b0, q} < MOD_X);
  assign at_max  = (q == MAX);
  assign at_zero = (q == '0);

  assign m_ld  = bus.LOAD & d_ok;
  assign m_err = bus.LOAD & ~d_ok;
  assign m_up  = ~bus.LOAD & bus.EN & bus.UP;
  assign m_dn  = ~bus.LOAD & bus.EN & ~bus.UP;

  // out-of-range state (forced/X) collapses to 0 on any count
  always_comb begin
    up_nxt = q + W'(1);
    if (!q_ok || at_max)
      up_nxt = '0;
  end

  always_comb begin
    dn_nxt = q - W'(1);
    if (!q_ok)
      dn_nxt = '0;
    else if (at_zero)
      dn_nxt = MAX;
  end

  always_comb begin
    nxt    = q;
    j      = '0;
    k      = '0;
    ld_bad = 1'b0;
    unique case (1'b1)
      m_ld: begin
        nxt = bus.D;
        j   = bus.D;
        k   = ~bus.D;
      end
      m_err: begin
        nxt    = '0;
        j      = '0;
        k      = '1;
        ld_bad = 1'b1;
      end
      m_up: begin
        nxt = up_nxt;
        j   = q ^ up_nxt;
        k   = q ^ up_nxt;
      end
      m_dn: begin
        nxt = dn_nxt;
        j   = q ^ dn_nxt;
        k   = q ^ dn_nxt;
      end
      default: begin
        nxt = q;
      end
    endcase
  end

  assign tc = bus.EN & ~bus.LOAD
            & ((bus.UP & at_max) | (~bus.UP & at_zero));

  generate
    for (genvar i = 0; i < W; i++) begin : g_cell
      logic c_q;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
          c_q <= 1'b0;
        else
          c_q <= (j[i] & ~c_q) | (~k[i] & c_q);
      end
      assign q[i] = c_q;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      load_err <= 1'b0;
    else
      load_err <= ld_bad;
  end

`ifdef JK_MOD_COUNTER_OVF_EN
  // a wrap on the same edge beats a clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      ovf <= 1'b0;
    else if (tc)
      ovf <= 1'b1;
    else if (bus.OVF_CLR)
      ovf <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = bus.OVF_CLR;
  assign ovf = 1'b0;
`endif

  logic [W-1:0] unused_nxt;
  assign unused_nxt = nxt;

  assign bus.Q        = q;
  assign bus.J_VEC    = j;
  assign bus.K_VEC    = k;
  assign bus.TC       = tc;
  assign bus.LOAD_ERR = load_err;
  assign bus.OVF      = ovf;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (W=4, MOD=10).
// OVF expectations follow JK_MOD_COUNTER_OVF_EN.
module tb_jk_mod_counter;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  int   exp_q;
  logic exp_ovf;

  jk_mod_counter_if #(.W(4)) bus ();

  jk_mod_counter #(.W(4), .MOD(10)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef JK_MOD_COUNTER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  initial begin
    total   = 0;
    passed  = 0;
    exp_ovf = 1'b0;
    rst_n       = 1'b0;
    bus.EN      = 1'b0;
    bus.UP      = 1'b1;
    bus.LOAD    = 1'b0;
    bus.D       = 4'd0;
    bus.OVF_CLR = 1'b0;
    step();
    step();
    chk("rst_q", bus.Q, 0);
    chk("rst_lerr", bus.LOAD_ERR, 0);
    chk("rst_ovf", bus.OVF, 0);

    rst_n  = 1'b1;
    bus.EN = 1'b1;
    bus.UP = 1'b1;
    exp_q  = 0;
    for (int i = 0; i < 12; i++) begin
      chk("up_tc", bus.TC, (exp_q == 9) ? 1 : 0);
      if (exp_q == 9 && OVF_ON) exp_ovf = 1'b1;
      step();
      exp_q = (exp_q + 1) % 10;
      chk("up_q", bus.Q, exp_q);
      chk("up_ovf", bus.OVF, exp_ovf);
    end

    bus.LOAD = 1'b1;
    bus.D    = 4'd0;
    step();
    chk("ld0_q", bus.Q, 0);
    bus.LOAD = 1'b0;
    bus.UP   = 1'b0;
    #1;
    chk("dn0_tc", bus.TC, 1);
    chk("dn0_j", bus.J_VEC, 4'b1001);
    chk("dn0_k", bus.K_VEC, 4'b1001);
    step();
    chk("dn_q9", bus.Q, 9);
    chk("dn_tc9", bus.TC, 0);
    step();
    chk("dn_q8", bus.Q, 8);
    step();
    chk("dn_q7", bus.Q, 7);
    chk("dn_ovf", bus.OVF, exp_ovf);

    bus.OVF_CLR = 1'b1;
    step();
    bus.OVF_CLR = 1'b0;
    exp_ovf = 1'b0;
    chk("clr_q", bus.Q, 6);
    chk("clr_ovf", bus.OVF, exp_ovf);

    bus.LOAD = 1'b1;
    bus.EN   = 1'b1;
    bus.UP   = 1'b1;
    bus.D    = 4'd7;
    #1;
    chk("ld7_tc", bus.TC, 0);
    chk("ld7_j", bus.J_VEC, 4'b0111);
    chk("ld7_k", bus.K_VEC, 4'b1000);
    step();
    chk("ld7_q", bus.Q, 7);
    chk("ld7_lerr", bus.LOAD_ERR, 0);

    bus.D = 4'd12;
    step();
    chk("ld12_q", bus.Q, 0);
    chk("ld12_lerr", bus.LOAD_ERR, 1);
    bus.LOAD = 1'b0;
    bus.EN   = 1'b0;
    step();
    chk("lerr_pulse", bus.LOAD_ERR, 0);
    chk("lerr_hold_q", bus.Q, 0);

    bus.LOAD = 1'b1;
    bus.D    = 4'd10;
    step();
    chk("ld10_q", bus.Q, 0);
    chk("ld10_lerr", bus.LOAD_ERR, 1);

    bus.D = 4'd5;
    step();
    chk("ld5_q", bus.Q, 5);
    chk("ld5_lerr", bus.LOAD_ERR, 0);
    bus.LOAD = 1'b0;
    bus.EN   = 1'b0;
    #1;
    chk("hold_j", bus.J_VEC, 0);
    chk("hold_k", bus.K_VEC, 0);
    chk("hold_tc", bus.TC, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_q", bus.Q, 5);
    end

    bus.LOAD = 1'b1;
    bus.D    = 4'd9;
    step();
    chk("ld9_q", bus.Q, 9);
    bus.LOAD    = 1'b0;
    bus.EN      = 1'b1;
    bus.UP      = 1'b1;
    bus.OVF_CLR = 1'b1;
    #1;
    chk("wrapclr_tc", bus.TC, 1);
    if (OVF_ON) exp_ovf = 1'b1;
    step();
    bus.OVF_CLR = 1'b0;
    chk("wrapclr_q", bus.Q, 0);
    chk("wrapclr_ovf", bus.OVF, exp_ovf);

    bus.LOAD = 1'b1;
    bus.D    = 4'd6;
    step();
    chk("ld6_q", bus.Q, 6);
    bus.LOAD = 1'b0;
    bus.EN   = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_q", bus.Q, 0);
    chk("arst_lerr", bus.LOAD_ERR, 0);
    chk("arst_ovf", bus.OVF, 0);
    #1;
    rst_n  = 1'b1;
    bus.EN = 1'b1;
    bus.UP = 1'b1;
    step();
    chk("arst_resume", bus.Q, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
